// File: rtl/op_memory_pkg.sv
// Shared definitions for the operation memory: operation word layout and device codes.
package op_memory_pkg;

   localparam int OP_W = 16;

   // Bit layout of one operation word: [15:5] argument, [4] device reset, [3:0] device.
   typedef struct packed {
      logic [10:0] arg;
      logic        rst;
      logic [3:0]  dev;
   } op_word_t;

   typedef enum logic [3:0] {
      DEV_NOP  = 4'd0,
      DEV_TIME = 4'd7
   } dev_e;

endpackage

// File: rtl/op_memory_ram.sv
// Single write port / single read port RAM with a registered read (read-before-write).
module op_memory_ram #(
   parameter int DW = 16,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/op_memory.sv
// Operation list loaded by the host and read back in order as a show-ahead queue.
module op_memory
   import op_memory_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic        wr_clr,
   input  logic        wr_lock,
   input  logic        mem_read,
   input  logic        mem_zero,
   output logic        mem_valid,
   output logic [3:0]  dev_no,
   output logic        dev_op_rst,
   output logic [10:0] op_arg,
   output logic [AW:0] count,
   output logic        full,
   output logic        wr_err
);

   localparam logic [AW:0] ONE     = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [AW:0]   rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic [AW:0]   count_next;
   logic [AW:0]   raddr;
   logic          valid_reg;
   logic          full_reg;
   logic          wr_err_reg;
   logic          wr_err_next;
   logic          bypass_reg;
   logic [OP_W-1:0] bypass_data_reg;
   logic [OP_W-1:0] ram_rdata;
   logic          wr_ok;
   logic          clr_ok;
   op_word_t      head_word;

   always_comb begin
      clr_ok      = wr_clr & ~wr_lock;
      wr_ok       = wr_en & ~wr_lock & ~full_reg & ~clr_ok;
      count_next  = count_reg;
      wr_err_next = wr_err_reg;
      raddr       = rd_ptr_reg;
      if (clr_ok) begin
         count_next  = '0;
         wr_err_next = 1'b0;
      end else begin
         if (wr_ok) begin
            count_next = count_reg + ONE;
         end
         if (wr_en && !wr_ok) begin
            wr_err_next = 1'b1;
         end
      end
      // Rewind (and clear) take priority over a pop; a pop needs a valid head.
      if (mem_zero || clr_ok) begin
         raddr = '0;
      end else if (mem_read && valid_reg) begin
         raddr = rd_ptr_reg + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
         valid_reg       <= 1'b0;
         full_reg        <= 1'b0;
         wr_err_reg      <= 1'b0;
         bypass_reg      <= 1'b0;
         bypass_data_reg <= '0;
      end else begin
         rd_ptr_reg      <= raddr;
         count_reg       <= count_next;
         valid_reg       <= (raddr < count_next);
         full_reg        <= (count_next == DEPTH_C);
         wr_err_reg      <= wr_err_next;
         // The RAM returns the old word when read and write hit the same index.
         bypass_reg      <= wr_ok && (count_reg == raddr);
         bypass_data_reg <= wr_data;
      end
   end

   op_memory_ram #(
      .DW (OP_W),
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (count_reg[AW-1:0]),
      .wdata (wr_data),
      .raddr (raddr[AW-1:0]),
      .rdata (ram_rdata)
   );

   always_comb begin
      head_word = '{arg: '0, rst: 1'b0, dev: DEV_NOP};
      if (valid_reg) begin
         head_word = bypass_reg ? op_word_t'(bypass_data_reg) : op_word_t'(ram_rdata);
      end
   end

   assign mem_valid  = valid_reg;
   assign dev_no     = head_word.dev;
   assign dev_op_rst = head_word.rst;
   assign op_arg     = head_word.arg;
   assign count      = count_reg;
   assign full       = full_reg;
   assign wr_err     = wr_err_reg;

endmodule

// File: tb/tb_op_memory.sv
// Scenario bench for op_memory: expected head words are queued as stimulus is driven.
module tb_op_memory;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        wr_clr;
   logic        wr_lock;
   logic        mem_read;
   logic        mem_zero;
   logic        mem_valid;
   logic [3:0]  dev_no;
   logic        dev_op_rst;
   logic [10:0] op_arg;
   logic [AW:0] count;
   logic        full;
   logic        wr_err;

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] exp_q [$];
   logic [15:0] exp_w;
   logic [15:0] head;

   assign head = {op_arg, dev_op_rst, dev_no};

   always #5 clk = ~clk;

   op_memory #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .wr_clr     (wr_clr),
      .wr_lock    (wr_lock),
      .mem_read   (mem_read),
      .mem_zero   (mem_zero),
      .mem_valid  (mem_valid),
      .dev_no     (dev_no),
      .dev_op_rst (dev_op_rst),
      .op_arg     (op_arg),
      .count      (count),
      .full       (full),
      .wr_err     (wr_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [15:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_clr = 1'b0; wr_lock = 1'b0;
      mem_read = 1'b0; mem_zero = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      n_checks++;
      if ({mem_valid, head, count, full, wr_err} !== '0)
         $display("FAIL reset_outputs: got valid=%b head=%h count=%0d full=%b err=%b required all 0",
                  mem_valid, head, count, full, wr_err);
      else n_pass++;
      $display("test_reset done");
   endtask

   task automatic test_write();
      write_word(16'h0011);
      write_word(16'h0022);
      write_word(16'h0007);
      n_checks++;
      if (count !== 11'd3) $display("FAIL write_count: got %0d required 3", count);
      else n_pass++;
      n_checks++;
      if (mem_valid !== 1'b1 || dev_no !== 4'd1 || dev_op_rst !== 1'b1)
         $display("FAIL write_head: got valid=%b dev=%0d rst=%b required 1/1/1",
                  mem_valid, dev_no, dev_op_rst);
      else n_pass++;
      $display("test_write done count=%0d", count);
   endtask

   task automatic test_pop_burst();
      exp_q.push_back(16'h0011);
      exp_q.push_back(16'h0022);
      exp_q.push_back(16'h0007);
      mem_read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_w = exp_q.pop_front();
         n_checks++;
         if (mem_valid !== 1'b1 || head !== exp_w)
            $display("FAIL pop_head_%0d: got valid=%b head=%h required 1 %h", i, mem_valid, head, exp_w);
         else n_pass++;
         tick();
      end
      mem_read = 1'b0;
      n_checks++;
      if (mem_valid !== 1'b0) $display("FAIL pop_end_valid: got %b required 0", mem_valid);
      else n_pass++;
      // A new word landing at the read pointer (index 3) shows up at once as the head.
      write_word(16'h0048);
      n_checks++;
      if (mem_valid !== 1'b1 || head !== 16'h0048)
         $display("FAIL pop_ptr_at_3: got valid=%b head=%h required 1 0048", mem_valid, head);
      else n_pass++;
      $display("test_pop_burst done");
   endtask

   task automatic test_rewind();
      mem_read = 1'b1; tick(); mem_read = 1'b0;
      mem_zero = 1'b1; tick(); mem_zero = 1'b0;
      n_checks++;
      if (mem_valid !== 1'b1 || head !== 16'h0011)
         $display("FAIL rewind_head: got valid=%b head=%h required 1 0011", mem_valid, head);
      else n_pass++;
      mem_read = 1'b1; mem_zero = 1'b1; tick();
      mem_read = 1'b0; mem_zero = 1'b0;
      n_checks++;
      if (head !== 16'h0011) $display("FAIL rewind_beats_pop: got head=%h required 0011", head);
      else n_pass++;
      tick();
      n_checks++;
      if (head !== 16'h0011) $display("FAIL rewind_hold: got head=%h required 0011", head);
      else n_pass++;
      $display("test_rewind done");
   endtask

   task automatic test_fill();
      logic [15:0] w;
      wr_clr = 1'b1; tick(); wr_clr = 1'b0;
      n_checks++;
      if (count !== '0 || mem_valid !== 1'b0)
         $display("FAIL fill_preclear: got count=%0d valid=%b required 0 0", count, mem_valid);
      else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
         w = 16'((i * 40503) ^ (i >> 3));
         exp_q.push_back(w);
         write_word(w);
      end
      n_checks++;
      if (count !== 11'(DEPTH) || full !== 1'b1 || wr_err !== 1'b0)
         $display("FAIL fill_full: got count=%0d full=%b err=%b required %0d 1 0", count, full, wr_err, DEPTH);
      else n_pass++;
      write_word(16'hBEEF);
      n_checks++;
      if (count !== 11'(DEPTH) || full !== 1'b1 || wr_err !== 1'b1)
         $display("FAIL fill_overflow: got count=%0d full=%b err=%b required %0d 1 1", count, full, wr_err, DEPTH);
      else n_pass++;
      mem_zero = 1'b1; tick(); mem_zero = 1'b0;
      mem_read = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         exp_w = exp_q.pop_front();
         n_checks++;
         if (mem_valid !== 1'b1 || head !== exp_w)
            $display("FAIL fill_entry_%0d: got valid=%b head=%h required 1 %h", i, mem_valid, head, exp_w);
         else n_pass++;
         tick();
      end
      mem_read = 1'b0;
      n_checks++;
      if (mem_valid !== 1'b0) $display("FAIL fill_drained: got valid=%b required 0", mem_valid);
      else n_pass++;
      wr_clr = 1'b1; tick(); wr_clr = 1'b0;
      n_checks++;
      if (count !== '0 || wr_err !== 1'b0 || mem_valid !== 1'b0 || full !== 1'b0)
         $display("FAIL fill_clear: got count=%0d err=%b valid=%b full=%b required 0 0 0 0",
                  count, wr_err, mem_valid, full);
      else n_pass++;
      $display("test_fill done");
   endtask

   task automatic test_lock();
      write_word(16'h0033);
      write_word(16'h0044);
      wr_lock = 1'b1;
      write_word(16'h0055);
      write_word(16'h0066);
      wr_clr = 1'b1; tick(); wr_clr = 1'b0;
      wr_lock = 1'b0;
      n_checks++;
      if (count !== 11'd2 || wr_err !== 1'b1)
         $display("FAIL lock_refused: got count=%0d err=%b required 2 1", count, wr_err);
      else n_pass++;
      exp_q.push_back(16'h0033);
      exp_q.push_back(16'h0044);
      mem_zero = 1'b1; tick(); mem_zero = 1'b0;
      mem_read = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_w = exp_q.pop_front();
         n_checks++;
         if (mem_valid !== 1'b1 || head !== exp_w)
            $display("FAIL lock_entry_%0d: got valid=%b head=%h required 1 %h", i, mem_valid, head, exp_w);
         else n_pass++;
         tick();
      end
      mem_read = 1'b0;
      wr_clr = 1'b1; tick(); wr_clr = 1'b0;
      n_checks++;
      if (count !== '0 || wr_err !== 1'b0)
         $display("FAIL lock_clear: got count=%0d err=%b required 0 0", count, wr_err);
      else n_pass++;
      $display("test_lock done");
   endtask

   task automatic test_bypass_and_reset();
      mem_read = 1'b1;
      write_word(16'h0015);
      n_checks++;
      if (mem_valid !== 1'b1 || dev_no !== 4'd5 || head !== 16'h0015)
         $display("FAIL bypass_head: got valid=%b head=%h required 1 0015", mem_valid, head);
      else n_pass++;
      tick();
      n_checks++;
      if (mem_valid !== 1'b0) $display("FAIL bypass_popped: got valid=%b required 0", mem_valid);
      else n_pass++;
      write_word(16'h0016);
      n_checks++;
      if (mem_valid !== 1'b1 || head !== 16'h0016)
         $display("FAIL bypass_second: got valid=%b head=%h required 1 0016", mem_valid, head);
      else n_pass++;
      wr_lock = 1'b1; write_word(16'h0017); wr_lock = 1'b0;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      mem_read = 1'b0;
      n_checks++;
      if ({mem_valid, head, count, full, wr_err} !== '0)
         $display("FAIL midrun_reset: got valid=%b head=%h count=%0d full=%b err=%b required all 0",
                  mem_valid, head, count, full, wr_err);
      else n_pass++;
      $display("test_bypass_and_reset done");
   endtask

   initial begin
      test_reset();
      test_write();
      test_pop_burst();
      test_rewind();
      test_fill();
      test_lock();
      test_bypass_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
